// File: rtl/acc_cpu_pkg.sv
// Shared types and instruction-field helpers for the parametrised accumulator CPU.
// Field helpers take a wide word plus the widths so one set serves every DATA_W/ADDR_W.
package acc_cpu_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpXor = 4'd2,
        OpDbl = 4'd3,
        OpLda = 4'd4,
        OpSta = 4'd5,
        OpCmm = 4'd6,
        OpAnd = 4'd7,
        OpJmp = 4'd8,
        OpJz  = 4'd9,
        OpJc  = 4'd10,
        OpInc = 4'd11,
        OpCla = 4'd12,
        OpShr = 4'd13,
        OpNop = 4'd14,
        OpHlt = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch0,
        StFetch1,
        StDecode,
        StIndirect,
        StExec,
        StHalt
    } state_e;

    function automatic logic ir_ind(input logic [63:0] ir, input int unsigned dw);
        return ir[dw-1];
    endfunction

    function automatic logic [3:0] ir_op(input logic [63:0] ir, input int unsigned dw);
        return ir[dw-2 -: 4];
    endfunction

    function automatic logic [63:0] ir_addr(input logic [63:0] ir, input int unsigned aw);
        return ir & ((64'd1 << aw) - 64'd1);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational datapath: one result word feeds either AC or memory, chosen by the enables.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  opcode_e           i_op,
    input  logic [DATA_W-1:0] i_ac,
    input  logic [DATA_W-1:0] i_m,
    input  logic              i_c,
    output logic [DATA_W-1:0] o_result,
    output logic              o_c,
    output logic              o_we_ac,
    output logic              o_we_m
);

    always_comb begin
        o_result = i_ac;
        o_c      = i_c;
        o_we_ac  = 1'b0;
        o_we_m   = 1'b0;
        unique case (i_op)
            OpAdd: begin
                {o_c, o_result} = {1'b0, i_ac} + {1'b0, i_m};
                o_we_ac = 1'b1;
            end
            // Top bit of the widened difference is the borrow.
            OpSub: begin
                {o_c, o_result} = {1'b0, i_ac} - {1'b0, i_m};
                o_we_ac = 1'b1;
            end
            OpXor: begin
                o_result = i_ac ^ i_m;
                o_we_ac  = 1'b1;
            end
            OpDbl: begin
                o_result = i_m + i_m;
                o_we_m   = 1'b1;
            end
            OpLda: begin
                o_result = i_m;
                o_we_ac  = 1'b1;
            end
            OpSta: begin
                o_result = i_ac;
                o_we_m   = 1'b1;
            end
            OpCmm: begin
                o_result = ~i_m;
                o_we_m   = 1'b1;
            end
            OpAnd: begin
                o_result = i_ac & i_m;
                o_we_ac  = 1'b1;
            end
            OpInc: begin
                {o_c, o_result} = {1'b0, i_ac} + (DATA_W+1)'(1);
                o_we_ac = 1'b1;
            end
            OpCla: begin
                o_result = '0;
                o_we_ac  = 1'b1;
            end
            OpShr: begin
                o_result = i_ac >> 1;
                o_c      = i_ac[0];
                o_we_ac  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU with unified internal memory, host load port and start/halt handshake.
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy,
    output logic              halted,
    output logic [DATA_W-1:0] ac_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              flag_z,
    output logic              flag_c
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_ac;
    logic              r_z;
    logic              r_c;
    logic              r_busy;
    logic              r_halted;
    logic [DATA_W-1:0] r_mem [Depth];

    logic              w_idle;
    logic              w_ind;
    opcode_e           w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_mem_rd;
    logic [DATA_W-1:0] w_result;
    logic              w_c_next;
    logic              w_we_ac;
    logic              w_we_m;
    logic              w_exec_we;
    logic              w_load_we;

    assign w_idle   = (r_state == StIdle) || (r_state == StHalt);
    assign w_ind    = ir_ind(64'(r_ir), DATA_W);
    assign w_op     = opcode_e'(ir_op(64'(r_ir), DATA_W));
    assign w_addr   = ADDR_W'(ir_addr(64'(r_ir), ADDR_W));
    assign w_mem_rd = r_mem[r_ar];

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_op),
        .i_ac     (r_ac),
        .i_m      (w_mem_rd),
        .i_c      (r_c),
        .o_result (w_result),
        .o_c      (w_c_next),
        .o_we_ac  (w_we_ac),
        .o_we_m   (w_we_m)
    );

    // Memory is only written in EXEC, so a reset earlier in the instruction abandons the store.
    assign w_exec_we = (r_state == StExec) && w_we_m;
    assign w_load_we = w_idle && load_en;

    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_mem[load_addr] <= load_data;
        end else if (w_exec_we) begin
            r_mem[r_ar] <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_pc     <= '0;
            r_ar     <= '0;
            r_ir     <= '0;
            r_ac     <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StHalt: begin
                    if (start) begin
                        r_state  <= StFetch0;
                        r_pc     <= '0;
                        r_ac     <= '0;
                        r_z      <= 1'b0;
                        r_c      <= 1'b0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                StFetch0: begin
                    r_ar    <= r_pc;
                    r_state <= StFetch1;
                end
                StFetch1: begin
                    r_ir    <= w_mem_rd;
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= StDecode;
                end
                StDecode: begin
                    r_ar    <= w_addr;
                    r_state <= w_ind ? StIndirect : StExec;
                end
                StIndirect: begin
                    r_ar    <= w_mem_rd[ADDR_W-1:0];
                    r_state <= StExec;
                end
                StExec: begin
                    if (w_we_ac) begin
                        r_ac <= w_result;
                        r_z  <= (w_result == '0);
                    end
                    r_c <= w_c_next;
                    if ((w_op == OpJmp) || (w_op == OpJz && r_z) || (w_op == OpJc && r_c)) begin
                        r_pc <= r_ar;
                    end
                    if (w_op == OpHlt) begin
                        r_state  <= StHalt;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= StFetch0;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign halted = r_halted;
    assign ac_out = r_ac;
    assign pc_out = r_pc;
    assign flag_z = r_z;
    assign flag_c = r_c;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: small programs with hand-computed results.
module tb_acc_cpu_param;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        busy;
    logic        halted;
    logic [15:0] ac_out;
    logic [7:0]  pc_out;
    logic        flag_z;
    logic        flag_c;

    int n_checks;
    int n_pass;

    acc_cpu_param #(
        .DATA_W (16),
        .ADDR_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy),
        .halted    (halted),
        .ac_out    (ac_out),
        .pc_out    (pc_out),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle load), count cycles to HALT.
    // disturb_at: cycle at which a load to 0x21 and a start pulse are driven while busy.
    task automatic run(input int disturb_at, input logic ld_with_start, input logic [7:0] la,
                       input logic [15:0] ld, output int cycles);
        @(negedge clk);
        start = 1'b1;
        if (ld_with_start) begin
            load_en   = 1'b1;
            load_addr = la;
            load_data = ld;
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        load_en = 1'b0;
        cycles  = 0;
        while (!halted && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
            load_en = 1'b0;
            start   = 1'b0;
            if (cycles == disturb_at) begin
                load_en   = 1'b1;
                load_addr = 8'h21;
                load_data = 16'h1234;
                start     = 1'b1;
            end
        end
        load_en = 1'b0;
        start   = 1'b0;
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    // Read a memory word through the CPU itself: LDA a; HLT (clobbers M[0], M[1]).
    task automatic peek(input logic [7:0] a, output logic [15:0] d);
        int cyc;
        load_word(8'h00, 16'h2000 | 16'(a));
        load_word(8'h01, 16'h7800);
        run(-1, 1'b0, 8'h00, 16'h0000, cyc);
        d = ac_out;
    endtask

    task automatic load_basic(input logic [15:0] m20, input logic [15:0] m21);
        load_word(8'h00, 16'h2020);
        load_word(8'h01, 16'h0021);
        load_word(8'h02, 16'h2822);
        load_word(8'h03, 16'h7800);
        load_word(8'h20, m20);
        load_word(8'h21, m21);
    endtask

    initial begin
        int          cyc;
        logic [15:0] m;
        logic [7:0]  ma [14];
        logic [15:0] md [14];

        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ac", 32'(ac_out), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_flags", 32'({flag_z, flag_c}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: 5 + 7 = 12 stored to 0x22
        load_basic(16'd5, 16'd7);
        run(-1, 1'b0, 8'h00, 16'h0000, cyc);
        check("basic_cycles", 32'(cyc), 32'd16);
        check("basic_ac", 32'(ac_out), 32'h000C);
        check("basic_z", 32'(flag_z), 32'd0);
        check("basic_c", 32'(flag_c), 32'd0);
        check("basic_pc", 32'(pc_out), 32'd4);
        check("basic_busy", 32'(busy), 32'd0);
        peek(8'h22, m);
        check("basic_m22", 32'(m), 32'h000C);

        // Carry/zero: FFFF + 1
        load_basic(16'hFFFF, 16'h0001);
        run(-1, 1'b0, 8'h00, 16'h0000, cyc);
        check("carry_ac", 32'(ac_out), 32'h0000);
        check("carry_z", 32'(flag_z), 32'd1);
        check("carry_c", 32'(flag_c), 32'd1);
        peek(8'h22, m);
        check("carry_m22", 32'(m), 32'h0000);

        // Borrow: 3 - 5
        load_word(8'h00, 16'h2020);
        load_word(8'h01, 16'h0821);
        load_word(8'h02, 16'h7800);
        load_word(8'h20, 16'd3);
        load_word(8'h21, 16'd5);
        run(-1, 1'b0, 8'h00, 16'h0000, cyc);
        check("sub_ac", 32'(ac_out), 32'hFFFE);
        check("sub_c", 32'(flag_c), 32'd1);
        check("sub_z", 32'(flag_z), 32'd0);

        // Indirect LDA; HLT at M[1] loaded in the same cycle as start
        load_word(8'h00, 16'hA020);
        load_word(8'h01, 16'h6000);
        load_word(8'h20, 16'h0030);
        load_word(8'h30, 16'hBEEF);
        run(-1, 1'b1, 8'h01, 16'h7800, cyc);
        check("ind_ac", 32'(ac_out), 32'hBEEF);
        check("ind_cycles", 32'(cyc), 32'd9);
        check("ind_pc", 32'(pc_out), 32'd2);

        // Branch and PC wrap: JZ not taken, JMP FF, CLA wraps to 0, JZ taken to HLT at 0x10
        load_word(8'h00, 16'h4810);
        load_word(8'h01, 16'h40FF);
        load_word(8'hFF, 16'h6000);
        load_word(8'h10, 16'h7800);
        run(-1, 1'b0, 8'h00, 16'h0000, cyc);
        check("br_cycles", 32'(cyc), 32'd20);
        check("br_pc", 32'(pc_out), 32'h11);
        check("br_z", 32'(flag_z), 32'd1);

        // Mixed ops: XOR, AND, DBL, CMM, SHR (C=1), JC taken, INC
        ma = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
               8'h20, 8'h21, 8'h22};
        md = '{16'h2020, 16'h1021, 16'h3822, 16'h1821, 16'h3022, 16'h6800, 16'h5009, 16'h7800,
               16'h7800, 16'h5800, 16'h7800, 16'h00F2, 16'h0F0F, 16'h00FF};
        for (int i = 0; i < 14; i++) begin
            load_word(ma[i], md[i]);
        end
        run(-1, 1'b0, 8'h00, 16'h0000, cyc);
        check("mix_ac", 32'(ac_out), 32'h007F);
        check("mix_c", 32'(flag_c), 32'd0);
        check("mix_pc", 32'(pc_out), 32'h0B);
        check("mix_cycles", 32'(cyc), 32'd36);
        peek(8'h21, m);
        check("mix_dbl", 32'(m), 32'h1E1E);
        peek(8'h22, m);
        check("mix_cmm", 32'(m), 32'hFF00);

        // Busy gating: load and start pulses mid-run are ignored
        load_basic(16'd5, 16'd7);
        run(3, 1'b0, 8'h00, 16'h0000, cyc);
        check("gate_ac", 32'(ac_out), 32'h000C);
        check("gate_cycles", 32'(cyc), 32'd16);
        peek(8'h21, m);
        check("gate_m21", 32'(m), 32'h0007);

        // Asynchronous reset during cycle 6, then rerun
        load_basic(16'd5, 16'd7);
        load_word(8'h22, 16'hAAAA);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_ac", 32'(ac_out), 32'd0);
        check("arst_pc", 32'(pc_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        peek(8'h22, m);
        check("arst_m22", 32'(m), 32'hAAAA);
        load_basic(16'd5, 16'd7);
        run(-1, 1'b0, 8'h00, 16'h0000, cyc);
        check("arst_rerun_ac", 32'(ac_out), 32'h000C);
        check("arst_rerun_cycles", 32'(cyc), 32'd16);
        peek(8'h20, m);
        check("arst_m20", 32'(m), 32'h0005);
        peek(8'h21, m);
        check("arst_m21", 32'(m), 32'h0007);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
- Parametrised accumulator CPU: the next generation of the team's 8-bit, 16-word, 3-bit-opcode accumulator core.
- Generalised in data width and address width, with a 4-bit opcode space that adds branches, flags and halt.
- Has an external program-load port and a start/halted handshake so a testbench or host can program it and run it.
- Unified instruction/data memory held inside the block.

Parameters:
- DATA_W, 16, word width of memory, AC and IR; must satisfy DATA_W >= ADDR_W+5.
- ADDR_W, 8, address width; memory depth = 2**ADDR_W words.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  1-cycle run request; honoured in IDLE or HALT only
- load_en  in  1  memory write strobe; honoured in IDLE or HALT only
- load_addr  in  ADDR_W  load address
- load_data  in  DATA_W  load data
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- ac_out  out  DATA_W  accumulator
- pc_out  out  ADDR_W  program counter
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag

Behaviour:
- Instruction format: bit DATA_W-1 = I (indirect); bits DATA_W-2..DATA_W-5 = opcode; bits ADDR_W-1..0 = address; remaining bits ignored.
- Memory: register array, combinational read, one write per cycle. Not cleared by reset.
- Reset (async): state=IDLE; PC, AR, IR, AC, Z, C all 0; busy=0, halted=0.
- FSM:
  - IDLE/HALT --start--> FETCH0. On start: PC=0, AC=0, Z=0, C=0.
  - FETCH0: AR<=PC.
  - FETCH1: IR<=M[AR]; PC<=PC+1 (wraps 2**ADDR_W-1 -> 0).
  - DECODE: AR<=IR address field. Next state is INDIRECT if I=1, else EXEC.
  - INDIRECT: AR<=M[AR][ADDR_W-1:0].
  - EXEC: perform the opcode, then go to FETCH0 (HLT goes to HALT).
- Latency: direct instruction 4 cycles; indirect 5 cycles.
- Opcodes (M = M[AR]):
  - 0 ADD: AC<=AC+M; C = carry-out.
  - 1 SUB: AC<=AC-M; C = borrow.
  - 2 XOR: AC<=AC^M.
  - 3 DBL: M<=M+M.
  - 4 LDA: AC<=M.
  - 5 STA: M<=AC.
  - 6 CMM: M<=~M.
  - 7 AND: AC<=AC&M.
  - 8 JMP: PC<=AR.
  - 9 JZ: if Z, PC<=AR.
  - 10 JC: if C, PC<=AR.
  - 11 INC: AC<=AC+1; C = carry-out.
  - 12 CLA: AC<=0.
  - 13 SHR: AC<=AC>>1 logical; C = old AC[0].
  - 14 NOP.
  - 15 HLT.
- Flags:
  - Z is updated from the new AC on every AC-writing op (0, 1, 2, 4, 7, 11, 12, 13).
  - C changes only on 0, 1, 11 and 13.
  - All other ops preserve both flags.
- Arithmetic is modulo 2**DATA_W.
- Indirect addressing applies uniformly, including to jumps: the target is taken from the pointer word.
- load_en while busy: ignored, memory unchanged.
- load_en and start in the same cycle: the write completes and the run starts; the loaded word is visible to the first fetch.
- start while busy: ignored.
- Reset mid-instruction: a STA/DBL/CMM write not yet in EXEC is abandoned; memory keeps its prior contents.
- In HALT, PC points past the HLT instruction.

Decomposition:
- Package acc_cpu_pkg holds:
  - the opcode enum (4 bits, values above);
  - the state enum {IDLE, FETCH0, FETCH1, DECODE, INDIRECT, EXEC, HALT};
  - functions extracting the I, opcode and address fields given DATA_W/ADDR_W.
- One natural sub-module: acc_cpu_alu, combinational. Inputs: op, AC, M, C. Outputs: result, next C, write-AC and write-M enables.

Test Plan (DATA_W=16, ADDR_W=8; opcode at bits 14:11):
- Basic sequence:
  - Load M[0]=0x2020 (LDA 20), M[1]=0x0021 (ADD 21), M[2]=0x2822 (STA 22), M[3]=0x7800 (HLT), M[0x20]=5, M[0x21]=7; pulse start.
  - Expect halted after 16 cycles, M[0x22]=0x000C, ac_out=0x000C, Z=0, C=0, pc_out=4.
- Carry/zero: same program with M[0x20]=0xFFFF, M[0x21]=0x0001 -> ac_out=0x0000, Z=1, C=1, M[0x22]=0.
- Indirect: M[0]=0xA020 (LDA indirect), M[0x20]=0x0030, M[0x30]=0xBEEF, M[1]=0x7800 -> ac_out=0xBEEF; first instruction takes 5 cycles, halted at cycle 9.
- Branch and PC wrap:
  - M[0]=0x4810 (JZ 10), M[1]=0x40FF (JMP FF), M[0xFF]=0x6000 (CLA), M[0x10]=0x7800.
  - Expect: JZ not taken first pass; PC wraps FF->00; JZ taken second pass; halt with pc_out=0x11, Z=1.
- Busy gating:
  - While running test 1, drive load_en with load_addr=0x21, load_data=0x1234 -> M[0x21] still 7, result 0x000C.
  - A start pulse mid-run has no effect.
- Reset mid-run: deassert rst_n asynchronously during cycle 6 of test 1 -> immediately busy=0, halted=0, ac_out=0, pc_out=0; M[0x20]/M[0x21] intact; a new start reruns to the same result.
